// File: rtl/decoding_unit_if.sv
// Decode-stage bundle: instruction/flags from fetch+ALU, registered decode fields to execute.
// master drives instruction and flags; slave (the decoder) drives the decoded outputs.
interface decoding_unit_if;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        zero;
  logic        neg;
  logic        ovf;

  logic [1:0]  cond;
  logic [3:0]  opcode;
  logic [2:0]  dest_reg;
  logic [2:0]  source_reg1;
  logic [2:0]  source_reg2;
  logic [6:0]  load_shift;
  logic        condition_code_success;
  logic        decode_valid;

  modport master (
    output instruction, instr_valid, zero, neg, ovf,
    input  cond, opcode, dest_reg, source_reg1, source_reg2, load_shift,
           condition_code_success, decode_valid
  );

  modport slave (
    input  instruction, instr_valid, zero, neg, ovf,
    output cond, opcode, dest_reg, source_reg1, source_reg2, load_shift,
           condition_code_success, decode_valid
  );
endinterface

// File: rtl/decoding_unit.sv
// Instruction decode: field slicing plus condition-code check, registered for execute.
// Latency 1 cycle, one instruction per cycle; no backpressure, outputs hold when instr_valid=0.
module decoding_unit (
  input  logic           clk,
  input  logic           rst,
  decoding_unit_if.slave dec
);

  typedef struct packed {
    logic [1:0] cond;
    logic [3:0] opcode;
    logic [2:0] dest_reg;
    logic [2:0] source_reg1;
    logic [2:0] source_reg2;
    logic [6:0] load_shift;
  } fields_t;

  fields_t fields_d;
  fields_t fields_q;
  logic    success_d;
  logic    success_q;
  logic    valid_q;

  // Pure slice; load_shift deliberately overlaps both source fields and bit 0.
  always_comb begin
    fields_d.cond        = dec.instruction[15:14];
    fields_d.opcode      = dec.instruction[13:10];
    fields_d.dest_reg    = dec.instruction[9:7];
    fields_d.source_reg1 = dec.instruction[6:4];
    fields_d.source_reg2 = dec.instruction[3:1];
    fields_d.load_shift  = dec.instruction[6:0];
  end

  // Mux on cond only, so an unselected (possibly X) flag never reaches success.
  always_comb begin
    success_d = 1'b0;
    case (dec.instruction[15:14])
      2'b00:   success_d = 1'b1;
      2'b01:   success_d = dec.zero;
      2'b10:   success_d = dec.neg;
      2'b11:   success_d = dec.ovf;
      default: success_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fields_q  <= '0;
      success_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= dec.instr_valid;
      if (dec.instr_valid) begin
        fields_q  <= fields_d;
        success_q <= success_d;
      end
    end
  end

  assign dec.cond                   = fields_q.cond;
  assign dec.opcode                 = fields_q.opcode;
  assign dec.dest_reg               = fields_q.dest_reg;
  assign dec.source_reg1            = fields_q.source_reg1;
  assign dec.source_reg2            = fields_q.source_reg2;
  assign dec.load_shift             = fields_q.load_shift;
  assign dec.condition_code_success = success_q;
  assign dec.decode_valid           = valid_q;

endmodule

// File: tb/tb_decoding_unit.sv
// Self-checking bench for decoding_unit: directed scenarios plus random back-to-back stream.
module tb_decoding_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [23:0] exp_q[$];

  decoding_unit_if dif();

  decoding_unit dut (
    .clk (clk),
    .rst (rst),
    .dec (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all outputs: {cond, opcode, dest, src1, src2, load_shift, success, valid}
  function automatic logic [23:0] obs();
    return {dif.cond, dif.opcode, dif.dest_reg, dif.source_reg1, dif.source_reg2,
            dif.load_shift, dif.condition_code_success, dif.decode_valid};
  endfunction

  function automatic logic [23:0] model(input logic [15:0] i, input logic z, input logic n,
                                        input logic v);
    logic s;
    case (i[15:14])
      2'b00:   s = 1'b1;
      2'b01:   s = z;
      2'b10:   s = n;
      default: s = v;
    endcase
    return {i[15:14], i[13:10], i[9:7], i[6:4], i[3:1], i[6:0], s, 1'b1};
  endfunction

  task automatic drive(input logic [15:0] i, input logic vld, input logic z, input logic n,
                       input logic v);
    @(negedge clk);
    dif.instruction = i;
    dif.instr_valid = vld;
    dif.zero        = z;
    dif.neg         = n;
    dif.ovf         = v;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    logic [23:0] o;
    rst = 1'b0;
    dif.instruction = 16'h0;
    dif.instr_valid = 1'b0;
    dif.zero = 1'b0;
    dif.neg  = 1'b0;
    dif.ovf  = 1'b0;
    #1;
    checks++;
    o = obs();
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_initial got %h exp %h", o, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(16'h4EAD, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({2'b01, 4'b0011, 3'b101, 3'b010, 3'b110, 7'b0101101, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_pre_load got %h exp %h", o, e);
    end
    // Asynchronous assert in the high phase, no clock edge involved.
    #2;
    rst = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", o, 24'h0);
    end
    // Valid instruction presented while reset is held must be discarded.
    dif.instruction = 16'hFFFF;
    dif.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    o = obs();
    checks++;
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_held got %h exp %h", o, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    dif.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    o = obs();
    checks++;
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_release_idle got %h exp %h", o, 24'h0);
    end
  endtask

  task automatic run_table(input string name, input logic [15:0] ins[], input logic [2:0] flg[],
                           input logic [23:0] exps[]);
    logic [23:0] e;
    logic [23:0] o;
    for (int k = 0; k < ins.size(); k++) begin
      drive(ins[k], 1'b1, flg[k][2], flg[k][1], flg[k][0]);
      exp_q.push_back(exps[k]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s[%0d] got %h exp %h", name, k, o, e);
      end
    end
  endtask

  task automatic test_field_slice();
    logic [15:0] ins[]  = '{16'h4EAD, 16'h4EAD};
    logic [2:0]  flg[]  = '{3'b100, 3'b011};
    logic [23:0] exps[] = '{
      {2'b01, 4'b0011, 3'b101, 3'b010, 3'b110, 7'b0101101, 1'b1, 1'b1},
      {2'b01, 4'b0011, 3'b101, 3'b010, 3'b110, 7'b0101101, 1'b0, 1'b1}};
    run_table("field_slice", ins, flg, exps);
  endtask

  task automatic test_always_neg();
    // Flags {zero, neg, ovf}; last row carries X on the unselected flags.
    logic [15:0] ins[]  = '{16'h0000, 16'h8000, 16'h8000, 16'h4000};
    logic [2:0]  flg[]  = '{3'b000, 3'b010, 3'b101, 3'b1xx};
    logic [23:0] exps[] = '{
      {22'h0, 1'b1, 1'b1},
      {2'b10, 20'h0, 1'b1, 1'b1},
      {2'b10, 20'h0, 1'b0, 1'b1},
      {2'b01, 20'h0, 1'b1, 1'b1}};
    run_table("always_neg", ins, flg, exps);
  endtask

  task automatic test_ovf_ones();
    logic [15:0] ins[]  = '{16'hFFFF, 16'hFFFF};
    logic [2:0]  flg[]  = '{3'b001, 3'b110};
    logic [23:0] exps[] = '{{22'h3FFFFF, 1'b1, 1'b1}, {22'h3FFFFF, 1'b0, 1'b1}};
    run_table("ovf_ones", ins, flg, exps);
  endtask

  task automatic test_hold();
    logic [23:0] a;
    logic [23:0] e;
    logic [23:0] o;
    a = {2'b01, 4'b0011, 3'b101, 3'b010, 3'b110, 7'b0101101, 1'b1, 1'b1};
    drive(16'h4EAD, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(a);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL hold_load got %h exp %h", o, e);
    end
    for (int k = 0; k < 2; k++) begin
      drive(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({a[23:1], 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hold_idle[%0d] got %h exp %h", k, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i;
    logic        z;
    logic        n;
    logic        v;
    logic [23:0] e;
    logic [23:0] o;
    for (int k = 0; k < 35; k++) begin
      i = 16'($urandom);
      z = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      drive(i, 1'b1, z, n, v);
      exp_q.push_back(model(i, z, n, v));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random[%0d] instr=%h got %h exp %h", k, i, o, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_field_slice();
    test_always_neg();
    test_ovf_ones();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
